// File: rtl/systolic_pkg.sv
// Shared types and constants for the 2x2 systolic MAC controller.
package systolic_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // One operand step: column k of A (a0, a1) and row k of B (b0, b1).
  typedef struct packed {
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b0;
    logic [DATA_W-1:0] b1;
  } operands_t;

endpackage

// File: rtl/systolic_ctrl_2x2_res_reg.sv
// Result register: captures the four accumulators once per job and holds
// them stable on a valid/ready port until the consumer accepts them.
module systolic_res_reg
  import systolic_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [ACC_W-1:0] cap_c00,
  input  logic [ACC_W-1:0] cap_c01,
  input  logic [ACC_W-1:0] cap_c10,
  input  logic [ACC_W-1:0] cap_c11,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [ACC_W-1:0] res_c00,
  output logic [ACC_W-1:0] res_c01,
  output logic [ACC_W-1:0] res_c10,
  output logic [ACC_W-1:0] res_c11
);

  // Capture has priority; data only moves on capture, so it is stable while valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_c00   <= {ACC_W{1'b0}};
      res_c01   <= {ACC_W{1'b0}};
      res_c10   <= {ACC_W{1'b0}};
      res_c11   <= {ACC_W{1'b0}};
    end else begin
      if (capture) begin
        res_valid <= 1'b1;
        res_c00   <= cap_c00;
        res_c01   <= cap_c01;
        res_c10   <= cap_c10;
        res_c11   <= cap_c11;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end else begin
        res_valid <= res_valid;
      end
    end
  end

endmodule

// File: rtl/systolic_ctrl_2x2.sv
// Job sequencer for a 2x2 MAC array: clear, feed K operand steps, drain the
// PE pipeline, then present the captured accumulators on a result port.
module systolic_ctrl_2x2
  import systolic_pkg::*;
#(
  parameter int KW     = 8,
  parameter int PE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a0,
  input  logic [DATA_W-1:0] in_a1,
  input  logic [DATA_W-1:0] in_b0,
  input  logic [DATA_W-1:0] in_b1,
  output logic              arr_clr,
  output logic              arr_en,
  output logic [DATA_W-1:0] arr_a0,
  output logic [DATA_W-1:0] arr_a1,
  output logic [DATA_W-1:0] arr_b0,
  output logic [DATA_W-1:0] arr_b1,
  input  logic [ACC_W-1:0]  arr_c00,
  input  logic [ACC_W-1:0]  arr_c01,
  input  logic [ACC_W-1:0]  arr_c10,
  input  logic [ACC_W-1:0]  arr_c11,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_c00,
  output logic [ACC_W-1:0]  res_c01,
  output logic [ACC_W-1:0]  res_c10,
  output logic [ACC_W-1:0]  res_c11
);

  localparam int DRAIN_W = $clog2(PE_LAT + 2);

  state_t              state;
  state_t              next_state;
  logic [KW-1:0]       rem_cnt;
  logic [KW-1:0]       rem_next;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic [DRAIN_W-1:0]  drain_next;
  logic                hs;
  logic                capture;
  operands_t           ops;

  assign arr_a0 = ops.a0;
  assign arr_a1 = ops.a1;
  assign arr_b0 = ops.b0;
  assign arr_b1 = ops.b1;

  // The array clear follows reset directly so the accumulators are held clear during it.
  assign arr_clr = rst | (state == CLEAR);

  // Next-state, counter and handshake decode.
  always_comb begin
    next_state = state;
    rem_next   = rem_cnt;
    drain_next = drain_cnt;
    hs         = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = CLEAR;
          rem_next   = k_len;
        end else begin
          next_state = IDLE;
        end
      end
      CLEAR: begin
        drain_next = {DRAIN_W{1'b0}};
        if (rem_cnt != {KW{1'b0}}) begin
          next_state = FEED;
        end else begin
          next_state = DRAIN;
        end
      end
      FEED: begin
        if (in_valid && in_ready) begin
          hs       = 1'b1;
          rem_next = rem_cnt - KW'(1);
          if (rem_cnt == KW'(1)) begin
            next_state = DRAIN;
            drain_next = {DRAIN_W{1'b0}};
          end else begin
            next_state = FEED;
          end
        end else begin
          next_state = FEED;
        end
      end
      DRAIN: begin
        // Final arr_en plus PE_LAT cycles for the last product to land.
        if (drain_cnt == DRAIN_W'(PE_LAT)) begin
          capture    = 1'b1;
          next_state = DONE;
        end else begin
          drain_next = drain_cnt + DRAIN_W'(1);
        end
      end
      DONE: begin
        if (res_valid && res_ready) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, counters and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rem_cnt   <= {KW{1'b0}};
      drain_cnt <= {DRAIN_W{1'b0}};
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      arr_en    <= 1'b0;
    end else begin
      state     <= next_state;
      rem_cnt   <= rem_next;
      drain_cnt <= drain_next;
      busy      <= (next_state != IDLE);
      in_ready  <= (next_state == FEED) && (rem_next != {KW{1'b0}});
      arr_en    <= hs;
    end
  end

  // Operand registers load only on an accepted step and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops <= {(4 * DATA_W){1'b0}};
    end else if (hs) begin
      ops <= {in_a0, in_a1, in_b0, in_b1};
    end else begin
      ops <= ops;
    end
  end

  systolic_res_reg u_res_reg (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .cap_c00   (arr_c00),
    .cap_c01   (arr_c01),
    .cap_c10   (arr_c10),
    .cap_c11   (arr_c11),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_c00   (res_c00),
    .res_c01   (res_c01),
    .res_c10   (res_c10),
    .res_c11   (res_c11)
  );

endmodule

// File: tb/tb_systolic_ctrl_2x2.sv
// Self-checking bench: drives jobs into the controller, models the 2x2 PE
// array around it, and checks results against a plain matrix-product model.
module tb_systolic_ctrl_2x2;

  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = 8'd0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_a0 = 8'd0, in_a1 = 8'd0, in_b0 = 8'd0, in_b1 = 8'd0;
  logic          arr_clr, arr_en;
  logic [7:0]    arr_a0, arr_a1, arr_b0, arr_b1;
  logic [15:0]   acc00 = 16'd0, acc01 = 16'd0, acc10 = 16'd0, acc11 = 16'd0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [15:0]   res_c00, res_c01, res_c10, res_c11;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int en_cnt = 0, hs_cnt = 0, clr_cnt = 0;
  int last_hs = 0;

  typedef struct { int a0; int a1; int b0; int b1; } step_t;
  step_t steps[$];

  systolic_ctrl_2x2 #(.KW(KW), .PE_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
    .arr_clr(arr_clr), .arr_en(arr_en),
    .arr_a0(arr_a0), .arr_a1(arr_a1), .arr_b0(arr_b0), .arr_b1(arr_b1),
    .arr_c00(acc00), .arr_c01(acc01), .arr_c10(acc10), .arr_c11(acc11),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_c00(res_c00), .res_c01(res_c01), .res_c10(res_c10), .res_c11(res_c11)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // PE array environment: one-cycle MAC accumulators with synchronous clear.
  always @(posedge clk) begin
    if (arr_clr) begin
      acc00 <= 16'd0; acc01 <= 16'd0; acc10 <= 16'd0; acc11 <= 16'd0;
    end else if (arr_en) begin
      acc00 <= acc00 + 16'(arr_a0) * 16'(arr_b0);
      acc01 <= acc01 + 16'(arr_a0) * 16'(arr_b1);
      acc10 <= acc10 + 16'(arr_a1) * 16'(arr_b0);
      acc11 <= acc11 + 16'(arr_a1) * 16'(arr_b1);
    end
  end

  always @(negedge clk) begin
    if (arr_en) en_cnt++;
    if (in_valid && in_ready) hs_cnt++;
    if (arr_clr) clr_cnt++;
  end

  // Reference: C = A * B summed over the steps, wrapped to 16 bits.
  function automatic logic [63:0] ref_result();
    int c00 = 0, c01 = 0, c10 = 0, c11 = 0;
    foreach (steps[i]) begin
      c00 += steps[i].a0 * steps[i].b0;
      c01 += steps[i].a0 * steps[i].b1;
      c10 += steps[i].a1 * steps[i].b0;
      c11 += steps[i].a1 * steps[i].b1;
    end
    return {16'(c00 % 65536), 16'(c01 % 65536), 16'(c10 % 65536), 16'(c11 % 65536)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int k);
    start = 1'b1;
    k_len = KW'(k);
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int gap);
    for (int s = 0; s < n; s++) begin
      int g;
      int wait_cnt;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : ((s == 0) ? 0 : gap);
      repeat (g) begin
        in_valid = 1'b0;
        in_a0 = 8'($urandom); in_a1 = 8'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_a0 = 8'(steps[s].a0); in_a1 = 8'(steps[s].a1);
      in_b0 = 8'(steps[s].b0); in_b1 = 8'(steps[s].b1);
      wait_cnt = 0;
      while (!in_ready && wait_cnt < 50) begin
        tick();
        wait_cnt++;
      end
      checks++;
      if (!in_ready) begin
        errors++;
        $display("FAIL feed_ready_timeout step=%0d got in_ready=%0b want 1", s, in_ready);
        in_valid = 1'b0;
        return;
      end
      last_hs = cyc;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int at);
    int n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    at = cyc;
    checks++;
    if (!res_valid) begin
      errors++;
      $display("FAIL result_timeout got res_valid=%0b want 1", res_valid);
    end
  endtask

  task automatic check_result(input string name);
    logic [63:0] exp;
    exp = ref_result();
    checks++;
    if ({res_c00, res_c01, res_c10, res_c11} !== exp) begin
      errors++;
      $display("FAIL %s got c00=%0d c01=%0d c10=%0d c11=%0d want c00=%0d c01=%0d c10=%0d c11=%0d",
               name, res_c00, res_c01, res_c10, res_c11,
               exp[63:48], exp[47:32], exp[31:16], exp[15:0]);
    end
  endtask

  task automatic ack(input string name);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack got res_valid=%0b busy=%0b want 0 0", name, res_valid, busy);
    end
  endtask

  task automatic run_job(input string name, input int gap);
    int at;
    start_job(steps.size());
    feed(steps.size(), gap);
    wait_result(at);
    check_result(name);
    ack(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || arr_en !== 1'b0 || res_valid !== 1'b0 ||
        arr_clr !== 1'b1 || {arr_a0, arr_a1, arr_b0, arr_b1} !== 32'd0 ||
        {res_c00, res_c01, res_c10, res_c11} !== 64'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%0b in_ready=%0b arr_en=%0b res_valid=%0b arr_clr=%0b want 0 0 0 0 1",
               busy, in_ready, arr_en, res_valid, arr_clr);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (arr_clr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got arr_clr=%0b busy=%0b want 0 0", arr_clr, busy);
    end
  endtask

  task automatic test_k1_latency();
    int at;
    steps = {};
    steps.push_back('{2, 3, 4, 5});
    start_job(1);
    feed(1, 0);
    wait_result(at);
    checks++;
    if (at - last_hs !== 3) begin
      errors++;
      $display("FAIL k1_latency got %0d cycles want 3", at - last_hs);
    end
    check_result("k1_result");
    ack("k1");
  endtask

  task automatic test_k2_gaps();
    int at;
    int en_base;
    en_base = en_cnt;
    steps = {};
    steps.push_back('{1, 2, 3, 4});
    steps.push_back('{5, 6, 7, 8});
    start_job(2);
    feed(2, 3);
    wait_result(at);
    checks++;
    if (en_cnt - en_base !== 2) begin
      errors++;
      $display("FAIL k2_arr_en_count got %0d want 2", en_cnt - en_base);
    end
    check_result("k2_result");
    ack("k2");
  endtask

  task automatic test_done_hold();
    int at;
    logic [63:0] held;
    steps = {};
    steps.push_back('{int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 255))});
    start_job(1);
    feed(1, 0);
    wait_result(at);
    held = ref_result();
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      k_len = 8'd5;
      tick();
      checks++;
      if (res_valid !== 1'b1 || busy !== 1'b1 || {res_c00, res_c01, res_c10, res_c11} !== held) begin
        errors++;
        $display("FAIL done_hold cycle=%0d got res_valid=%0b busy=%0b res=%h want 1 1 %h",
                 i, res_valid, busy, {res_c00, res_c01, res_c10, res_c11}, held);
      end
    end
    start = 1'b0;
    ack("hold");
    tick();
    checks++;
    if (busy !== 1'b0 || arr_clr !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_queued_start got busy=%0b arr_clr=%0b want 0 0", busy, arr_clr);
    end
  endtask

  task automatic test_wrap_then_clear();
    steps = {};
    steps.push_back('{255, 255, 255, 255});
    steps.push_back('{255, 255, 255, 255});
    run_job("wrap_result", 0);
    steps = {};
    steps.push_back('{1, 1, 1, 1});
    run_job("post_wrap_clear", 0);
  endtask

  task automatic test_k0();
    int at;
    int clr_base, hs_base;
    clr_base = clr_cnt;
    hs_base = hs_cnt;
    steps = {};
    start_job(0);
    in_valid = 1'b1;
    wait_result(at);
    in_valid = 1'b0;
    checks++;
    if (clr_cnt - clr_base !== 1 || hs_cnt - hs_base !== 0) begin
      errors++;
      $display("FAIL k0_counts got clr=%0d hs=%0d want 1 0", clr_cnt - clr_base, hs_cnt - hs_base);
    end
    check_result("k0_result");
    ack("k0");
  endtask

  task automatic test_reset_mid();
    steps = {};
    steps.push_back('{9, 8, 7, 6});
    steps.push_back('{5, 4, 3, 2});
    steps.push_back('{1, 2, 3, 4});
    start_job(3);
    feed(1, 0);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || res_valid !== 1'b0 || arr_clr !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got in_ready=%0b res_valid=%0b arr_clr=%0b busy=%0b want 0 0 1 0",
               in_ready, res_valid, arr_clr, busy);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_mid_reset got res_valid=%0b busy=%0b want 0 0", res_valid, busy);
    end
    steps = {};
    steps.push_back('{11, 12, 13, 14});
    run_job("fresh_after_reset", 0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      int k;
      int at;
      k = int'($urandom_range(1, 6));
      steps = {};
      for (int s = 0; s < k; s++) begin
        steps.push_back('{int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 255))});
      end
      start_job(k);
      feed(k, -1);
      wait_result(at);
      checks++;
      if (at - last_hs !== 3) begin
        errors++;
        $display("FAIL rand_latency job=%0d got %0d want 3", j, at - last_hs);
      end
      check_result("rand_result");
      repeat ($urandom_range(0, 4)) tick();
      ack("rand");
    end
  endtask

  initial begin
    test_reset();
    test_k1_latency();
    test_k2_gaps();
    test_done_hold();
    test_wrap_then_clear();
    test_k0();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl_2x2.md
Name: systolic_ctrl_2x2

Overview:
Sequencer for the 2x2 MAC array (four pe_mac accumulators, a0/a1 broadcast across rows, b0/b1 down columns).
- Runs one C = A(2xK) * B(Kx2) job per start.
- Clears the array, feeds K operand steps from a valid/ready stream, and drains the PE pipeline.
- Captures c00..c11 into a result register and hands it off on a valid/ready port.

Parameters:
KW, 8, width of k_len (K up to 2^KW-1)
PE_LAT, 1, cycles from arr_en-high cycle to updated arr_c* visible

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  job request, sampled only in IDLE
k_len  in  KW  inner dimension K, sampled with start
busy  out  1  high in any state except IDLE
in_valid  in  1  operand step valid
in_ready  out  1  controller accepts operand step
in_a0, in_a1, in_b0, in_b1  in  8 each  column k of A / row k of B
arr_clr  out  1  drives array rst (accumulator clear)
arr_en  out  1  drives array enable
arr_a0, arr_a1, arr_b0, arr_b1  out  8 each  registered operands to array
arr_c00, arr_c01, arr_c10, arr_c11  in  16 each  array accumulators
res_valid  out  1  result held valid
res_ready  in  1  result consumer accepts
res_c00, res_c01, res_c10, res_c11  out  16 each  captured result

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All outputs 0, except arr_clr=1 while rst is high.
  - Counters and result registers 0.
- FSM: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - in_ready=0, arr_en=0.
  - start=1 latches k_len into rem_cnt and goes to CLEAR.
- CLEAR:
  - Exactly 1 cycle, arr_clr=1, in_ready=0.
  - Next state FEED if rem_cnt!=0, else DRAIN (K=0 yields all-zero result).
- FEED:
  - in_ready=1 while rem_cnt!=0.
  - Handshake (in_valid & in_ready) registers in_* into arr_* and sets arr_en=1 for the following cycle; rem_cnt decrements.
  - No handshake: arr_en=0 next cycle, arr_* hold.
  - Handshake with rem_cnt==1: in_ready drops next cycle and state goes to DRAIN.
  - At most one handshake per cycle; throughput 1 step/cycle.
- DRAIN:
  - Lasts PE_LAT+1 cycles, counted by drain_cnt.
  - The first DRAIN cycle carries the final arr_en=1.
  - On the last DRAIN cycle's edge, res_c* <= arr_c* and res_valid <= 1; state goes to DONE.
- Latency, PE_LAT=1: last handshake at cycle T; arr_en high in T+1; capture at end of T+2; res_valid=1 from T+3.
- DONE:
  - res_valid=1; res_c* stable until handshake.
  - res_valid & res_ready -> res_valid=0 next cycle, IDLE.
  - A new start is not accepted in the same cycle as the result handshake.
- start while busy: ignored, no queueing.
- arr_clr: 0 outside CLEAR and reset.
- Arithmetic: the controller does no math. Accumulator wrap mod 2^16 is inherited from the PEs and passed through unchanged.
- Reset mid-job: immediate return to IDLE, in_ready=0, res_valid=0. A partial result is never presented.
- in_valid in IDLE/CLEAR/DRAIN/DONE is ignored; in_ready=0 there.

Decomposition:
- Package systolic_pkg:
  - state enum typedef (IDLE, CLEAR, FEED, DRAIN, DONE)
  - DATA_W=8 and ACC_W=16 constants
  - typedef for the four-lane operand bundle
- Sub-module systolic_res_reg: 4x16 capture register with valid/ready hold.
- The FSM, counters and operand registers stay in systolic_ctrl_2x2.

Test Plan:
- K=1, a=(2,3), b=(4,5), in_valid held high -> res c00=8, c01=10, c10=12, c11=15; res_valid exactly 3 cycles after the handshake cycle.
- K=2, steps a=(1,2)/b=(3,4) then a=(5,6)/b=(7,8), in_valid gap of 3 cycles between steps -> c00=38, c01=44, c10=48, c11=56; arr_en high exactly 2 cycles total.
- res_ready held 0 for 10 cycles after res_valid -> res_c* stable, busy=1, start pulses ignored; res_ready=1 -> IDLE next cycle.
- K=2, a=(255,255), b=(255,255) both steps -> all c=64514 (wrap mod 2^16); second job K=1, a=(1,1), b=(1,1) -> all c=1, proving CLEAR works.
- K=0 start -> one arr_clr cycle, zero handshakes, all results 0, res_valid asserted.
- rst pulse after 1 of 3 steps -> in_ready=0, res_valid=0, arr_clr=1 during rst; a fresh K=1 job then completes correctly.
